// File: rtl/mem_pkg.sv
// Shared helpers for the on-chip RAM family.
// Holds the legal READ_LATENCY values so every RAM checks them the same way.
package mem_pkg;

  function automatic bit legal_latency(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/dual_port_ram_out_stage.sv
// Per-port read output stage: rden-gated register, optional second pipe stage.
// All registers here clear on async reset; the RAM array itself never resets.
module ram_out_stage #(
  parameter int DATA_WIDTH = 56,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rden,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic                  upd;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] q_q;

  generate
    if (LATENCY == 2) begin : g_pipe
      logic                  v1_d;
      logic                  v1_q;
      logic [DATA_WIDTH-1:0] d1_d;
      logic [DATA_WIDTH-1:0] d1_q;

      always_comb begin
        v1_d = rden;
        d1_d = d1_q;
        if (rden) d1_d = d;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v1_q <= 1'b0;
          d1_q <= '0;
        end else begin
          v1_q <= v1_d;
          d1_q <= d1_d;
        end
      end

      assign upd = v1_q;
      assign din = d1_q;
    end else begin : g_direct
      assign upd = rden;
      assign din = d;
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (upd) q_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port single-clock RAM; port A wins a same-address double write.
// Reads return pre-write contents (old-data) on both ports.
module dual_port_ram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 56,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (!legal_latency(READ_LATENCY)) begin : g_bad_latency
      $error("dual_port_ram: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  collide;
  logic                  wr_b_en;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // Drop port B's write when both ports hit the same word
  assign collide = wren_a & wren_b & (address_a == address_b);
  assign wr_b_en = wren_b & ~collide;

  always_ff @(posedge clk) begin
    if (wren_a)  mem[address_a] <= data_a;
    if (wr_b_en) mem[address_b] <= data_b;
  end

  assign rd_a = mem[address_a];
  assign rd_b = mem[address_b];

  ram_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_out_a (
    .clk  (clk),
    .rst  (rst),
    .rden (rden_a),
    .d    (rd_a),
    .q    (q_a)
  );

  ram_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_out_b (
    .clk  (clk),
    .rst  (rst),
    .rden (rden_b),
    .d    (rd_b),
    .q    (q_b)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench: latency-1 and latency-2 RAMs driven in parallel.
// Expected reads come from a plain array model of the memory contents.
module tb_dual_port_ram;

  localparam int AW = 11;
  localparam int DW = 56;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address_a = '0;
  logic          wren_a = 1'b0;
  logic [DW-1:0] data_a = '0;
  logic          rden_a = 1'b0;
  logic [AW-1:0] address_b = '0;
  logic          wren_b = 1'b0;
  logic [DW-1:0] data_b = '0;
  logic          rden_b = 1'b0;
  logic [DW-1:0] q1_a, q1_b, q2_a, q2_b;

  exp_t          sb [4][$];
  logic [DW-1:0] cur [4];
  logic [DW-1:0] model [DEPTH];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a),
    .rden_a(rden_a), .q_a(q1_a),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b),
    .rden_b(rden_b), .q_b(q1_b)
  );

  dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a),
    .rden_a(rden_a), .q_a(q2_a),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b),
    .rden_b(rden_b), .q_b(q2_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] qof(input int k);
    case (k)
      0:       return q1_a;
      1:       return q1_b;
      2:       return q2_a;
      default: return q2_b;
    endcase
  endfunction

  function automatic string qname(input int k);
    case (k)
      0:       return "lat1_q_a";
      1:       return "lat1_q_b";
      2:       return "lat2_q_a";
      default: return "lat2_q_b";
    endcase
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: retire due reads, then every output must match its latest value
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      while (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
        cur[k] = sb[k][0].val;
        void'(sb[k].pop_front());
      end
      check(qname(k), qof(k), cur[k]);
    end
  end

  task automatic push(input int k, input int due, input logic [DW-1:0] v);
    exp_t e;
    e.due = due;
    e.val = v;
    sb[k].push_back(e);
  endtask

  task automatic drive(
    input logic          wa, input logic [AW-1:0] aa,
    input logic [DW-1:0] da, input logic          ra,
    input logic          wb, input logic [AW-1:0] ab,
    input logic [DW-1:0] db, input logic          rb
  );
    @(posedge clk);
    #1;
    wren_a = wa; address_a = aa; data_a = da; rden_a = ra;
    wren_b = wb; address_b = ab; data_b = db; rden_b = rb;
    if (!rst) begin
      if (ra) begin
        push(0, cyc + 1, model[aa]);
        push(2, cyc + 2, model[aa]);
      end
      if (rb) begin
        push(1, cyc + 1, model[ab]);
        push(3, cyc + 2, model[ab]);
      end
    end
    if (wb) model[ab] = db;
    if (wa) model[aa] = da;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  // early=1 asserts reset before the edge that would capture the pending read
  task automatic reset_pulse(input bit early);
    if (!early) begin
      @(posedge clk);
      #1;
      wren_a = 0; rden_a = 0; wren_b = 0; rden_b = 0;
    end
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      cur[k] = '0;
    end
    #1;
    for (int k = 0; k < 4; k++) check({qname(k), "_async_rst"}, qof(k), '0);
    @(posedge clk);
    #1;
    wren_a = 0; rden_a = 0; wren_b = 0; rden_b = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra_addr, rb_addr;
    logic [DW-1:0] rda, rdb;
    for (int k = 0; k < 4; k++) cur[k] = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    for (int i = 0; i < DEPTH; i++) drive(1, AW'(i), '0, 0, 0, '0, '0, 0);

    drive(1, 11'h041, 56'hFFFFFF_000000_41, 0, 0, '0, '0, 0);
    rst = 1'b0;
    drive(0, '0, '0, 0, 0, 11'h041, '0, 1);
    idle(2);
    check("t1_q_b", q1_b, 56'hFFFFFF00000041);
    check("t1_q_a", q1_a, '0);

    drive(1, 11'd5, 56'h0AA, 0, 0, '0, '0, 0);
    drive(1, 11'd5, 56'h0BB, 0, 0, 11'd5, '0, 1);
    drive(0, '0, '0, 0, 0, 11'd5, '0, 1);
    idle(1);
    check("t2_q_b_new", q1_b, 56'h0BB);

    drive(1, 11'h7FF, 56'h111, 0, 1, 11'h7FF, 56'h222, 0);
    drive(0, 11'h7FF, '0, 1, 0, 11'h7FF, '0, 1);
    idle(2);
    check("t3_prio_a", q1_a, 56'h111);
    check("t3_prio_b", q2_b, 56'h111);

    drive(1, 11'd3, 56'h123, 0, 0, '0, '0, 0);
    drive(0, '0, '0, 0, 0, 11'd3, '0, 1);
    drive(0, '0, '0, 0, 0, 11'h7FF, '0, 0);
    drive(0, '0, '0, 0, 0, 11'h041, '0, 0);
    idle(1);
    check("t4_hold", q1_b, 56'h123);

    drive(0, 11'd3, '0, 1, 0, '0, '0, 0);
    reset_pulse(1);
    idle(1);
    drive(0, 11'd3, '0, 1, 0, 11'd3, '0, 1);
    reset_pulse(0);
    drive(0, 11'd3, '0, 1, 0, '0, '0, 0);
    idle(2);
    check("t5_after_rst", q1_a, 56'h123);

    drive(1, 11'd9, 56'h55, 0, 0, '0, '0, 0);
    drive(0, 11'd9, '0, 1, 0, 11'd9, '0, 1);
    idle(3);
    check("t6_lat2", q2_b, 56'h55);

    for (int i = 0; i < 800; i++) begin
      ra_addr = ($urandom_range(0, 7) == 0) ? 11'h7FF : AW'($urandom_range(0, 7));
      rb_addr = ($urandom_range(0, 7) == 0) ? 11'h7FF : AW'($urandom_range(0, 7));
      rda = DW'({$urandom, $urandom});
      rdb = DW'({$urandom, $urandom});
      drive(1'($urandom_range(0, 1)), ra_addr, rda, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rb_addr, rdb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) reset_pulse(1'($urandom_range(0, 1)));
    end

    idle(4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        failures++;
        $display("FAIL %s_drain left=%0d want=0", qname(k), sb[k].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
